// File: rtl/ring_sequence_monitor.sv
// ring_sequence_monitor
// Run-time integrity checker for a one-hot ring counter. Registers the ring
// state twice, checks that every sample is one-hot and one position further
// toward the MSB than the previous sample (MSB wraps to bit 0), and reports
// lock/fault status, the current phase, a per-rotation wrap pulse, a rotation
// count and a saturating count of lock-loss events.
module ring_sequence_monitor #(
    parameter int WIDTH    = 4,
    parameter int ROT_W    = 8,
    parameter int ERR_W    = 4,
    parameter int LOCK_CNT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         q,
    input  logic                     clr,
    output logic                     locked,
    output logic                     fault,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     wrap,
    output logic [ROT_W-1:0]         rotations,
    output logic [ERR_W-1:0]         err_count
);

    localparam int PW = $clog2(WIDTH);
    localparam int GW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [GW-1:0]    good_cnt;
    logic [GW-1:0]    good_next;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_rr;
    logic             step_ok;
    logic             wrap_cond;
    logic [PW-1:0]    hot_idx;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // A step is valid when both samples are one-hot and the newer one is the
    // older one rotated left by a single position.
    assign step_ok = is_onehot(q_r) && is_onehot(q_rr) &&
                     (q_r == {q_rr[WIDTH-2:0], q_rr[WIDTH-1]});

    // A rotation completes on a valid MSB -> bit 0 step observed while locked.
    assign wrap_cond = (state == LOCKED) && step_ok && q_rr[WIDTH-1] && q_r[0];

    // Two-deep sample pipeline of the ring state.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every register is written with <= so that all flops update
        // from pre-edge values; blocking assignments here would let q_rr
        // pick up the new q_r in the same edge.
        if (!rst) begin
            q_r  <= '0;
            q_rr <= '0;
        end else begin
            q_r  <= q;
            q_rr <= q_r;
        end
    end

    // FSM state register and consecutive-good-step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SYNC;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // Next-state logic; clr overrides every other transition.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        state_next = state;
        good_next  = good_cnt;
        if (clr) begin
            state_next = SYNC;
            good_next  = '0;
        end else begin
            case (state)
                SYNC: begin
                    if (!step_ok) begin
                        good_next = '0;
                    end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
                        state_next = LOCKED;
                        good_next  = '0;
                    end else begin
                        good_next = good_cnt + GW'(1);
                    end
                end
                LOCKED: begin
                    if (!step_ok) begin
                        state_next = FAULT;
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = SYNC;
                    good_next  = '0;
                end
            endcase
        end
    end

    // Status flags decode directly from the registered state.
    always_comb begin
        locked = (state == LOCKED);
        fault  = (state == FAULT);
    end

    // Binary index of the hot bit in the newest sample.
    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_r[i]) begin
                hot_idx = PW'(i);
            end
        end
    end

    // Registered phase, wrap pulse, rotation counter and saturating fault counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     <= '0;
            wrap      <= 1'b0;
            rotations <= '0;
            err_count <= '0;
        end else begin
            phase <= (state_next == LOCKED) ? hot_idx : '0;
            wrap  <= wrap_cond;
            if (wrap_cond) begin
                rotations <= rotations + ROT_W'(1);
            end
            if ((state == LOCKED) && (state_next == FAULT) && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Self-checking bench for ring_sequence_monitor (WIDTH=4, LOCK_CNT=2).
// Table rows and scripted steps push their expected outputs into a queue
// tagged with the edge at which the response becomes visible; the queue is
// popped and compared after each clock edge.
module tb_ring_sequence_monitor;

    localparam int WIDTH = 4;
    localparam int NROWS = 43;

    typedef struct {
        int         due;
        int         tag;
        logic       locked;
        logic       fault;
        logic [1:0] phase;
        logic       wrap;
        logic [7:0] rot;
        logic [3:0] err;
    } exp_t;

    typedef struct {
        logic [3:0] q;
        logic       clr;
        logic       locked;
        logic       fault;
        logic [1:0] phase;
        logic       wrap;
        logic [7:0] rot;
        logic [3:0] err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q;
    logic       clr;
    logic       locked;
    logic       fault;
    logic [1:0] phase;
    logic       wrap;
    logic [7:0] rotations;
    logic [3:0] err_count;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ring_pos = 0;
    logic [3:0] last_q = 4'b0000;
    exp_t       sb[$];
    vec_t       tbl[NROWS];

    ring_sequence_monitor #(
        .WIDTH(WIDTH), .ROT_W(8), .ERR_W(4), .LOCK_CNT(2)
    ) dut (
        .clk(clk), .rst(rst), .q(q), .clr(clr),
        .locked(locked), .fault(fault), .phase(phase), .wrap(wrap),
        .rotations(rotations), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [3:0] nxt();
        logic [3:0] v;
        v = 4'b0001 << ring_pos;
        ring_pos = (ring_pos + 1) % 4;
        return v;
    endfunction

    task automatic sb_pop();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check($sformatf("r%0d_locked", e.tag), locked, e.locked);
            check($sformatf("r%0d_fault", e.tag), fault, e.fault);
            check($sformatf("r%0d_phase", e.tag), phase, e.phase);
            check($sformatf("r%0d_wrap", e.tag), wrap, e.wrap);
            check($sformatf("r%0d_rot", e.tag), rotations, e.rot);
            check($sformatf("r%0d_err", e.tag), err_count, e.err);
        end
    endtask

    // Response to the q driven in the next step is visible two edges later.
    task automatic push(input int tag, input logic l, input logic f, input logic [1:0] p,
                        input logic w, input logic [7:0] r, input logic [3:0] e);
        exp_t x;
        x.due = cyc + 2; x.tag = tag; x.locked = l; x.fault = f;
        x.phase = p; x.wrap = w; x.rot = r; x.err = e;
        sb.push_back(x);
    endtask

    task automatic step(input logic [3:0] qv, input logic cv);
        @(negedge clk);
        q = qv;
        clr = cv;
        last_q = qv;
        @(posedge clk);
        #1;
        cyc++;
        sb_pop();
    endtask

    task automatic apply_table(input int n);
        for (int i = 0; i < n; i++) begin
            push(i, tbl[i].locked, tbl[i].fault, tbl[i].phase, tbl[i].wrap, tbl[i].rot, tbl[i].err);
            step(tbl[i].q, tbl[i].clr);
        end
        ring_pos = n % 4;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && sb.size() > 0; k++) step(nxt(), 1'b0);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_locked"}, locked, 0);
        check({pfx, "_fault"}, fault, 0);
        check({pfx, "_phase"}, phase, 0);
        check({pfx, "_wrap"}, wrap, 0);
        check({pfx, "_rot"}, rotations, 0);
        check({pfx, "_err"}, err_count, 0);
    endtask

    initial begin
        rst = 1'b0;
        q   = 4'b0000;
        clr = 1'b0;

        // Ring sequence from reset: rows 0,1 cannot lock (first pair involves
        // the cleared pipeline); lock appears on row 2; wraps on rows 4,8,...
        for (int i = 0; i < NROWS; i++) begin
            tbl[i].q      = 4'b0001 << (i % 4);
            tbl[i].clr    = 1'b0;
            tbl[i].fault  = 1'b0;
            tbl[i].err    = 4'd0;
            tbl[i].locked = (i >= 2);
            tbl[i].phase  = (i >= 2) ? 2'(i % 4) : 2'd0;
            tbl[i].wrap   = (i >= 4) && (i % 4 == 0);
            tbl[i].rot    = 8'(i / 4);
        end

        // Scenario 1/2: reset, lock-in, 40 steps of rotation.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        cyc = 0;
        apply_table(NROWS);

        // Scenario 3: multi-hot while locked, then good steps; fault is sticky.
        push(100, 1, 0, 2'd3, 0, 8'd10, 4'd0);
        step(nxt(), 1'b0);
        push(101, 0, 1, 2'd0, 0, 8'd10, 4'd1);
        step(4'b0011, 1'b0);
        for (int k = 0; k < 20; k++) begin
            push(102 + k, 0, 1, 2'd0, 0, 8'd10, 4'd1);
            step(nxt(), 1'b0);
        end
        drain();

        // Scenario 4: clear from FAULT, relock, stall, clear again.
        step(nxt(), 1'b1);
        check("s4_clr_fault", fault, 0);
        check("s4_clr_locked", locked, 0);
        check("s4_clr_err", err_count, 1);
        step(nxt(), 1'b0);
        check("s4_relock1", locked, 0);
        step(nxt(), 1'b0);
        check("s4_relock2", locked, 1);
        step(last_q, 1'b0);
        check("s4_stall_still_locked", locked, 1);
        step(nxt(), 1'b0);
        check("s4_stall_fault", fault, 1);
        check("s4_stall_err", err_count, 2);
        step(nxt(), 1'b0);
        check("s4_sticky", fault, 1);
        step(nxt(), 1'b1);
        check("s4_clr2_fault", fault, 0);
        check("s4_clr2_err", err_count, 2);
        step(nxt(), 1'b0);
        check("s4_relock3", locked, 0);
        step(nxt(), 1'b0);
        check("s4_relock4", locked, 1);

        // Scenario 5a: clr on the same edge as a bad step.
        step(last_q, 1'b0);
        check("s5_pre_locked", locked, 1);
        step(nxt(), 1'b1);
        check("s5_prio_locked", locked, 0);
        check("s5_prio_fault", fault, 0);
        check("s5_prio_err", err_count, 2);
        step(nxt(), 1'b0);
        step(nxt(), 1'b0);
        check("s5_relock", locked, 1);

        // Scenario 5b: 17 fault/clear cycles, err_count saturates at 15.
        for (int k = 0; k < 17; k++) begin
            step(last_q, 1'b0);
            step(nxt(), 1'b0);
            check($sformatf("s5_sat%0d_fault", k), fault, 1);
            check($sformatf("s5_sat%0d_err", k), err_count, (k + 3 > 15) ? 15 : k + 3);
            step(nxt(), 1'b1);
            step(nxt(), 1'b0);
            step(nxt(), 1'b0);
            check($sformatf("s5_sat%0d_relock", k), locked, 1);
        end

        // Scenario 6: asynchronous reset between edges while locked.
        check("s6_pre_rot_nonzero", rotations != 8'd0, 1);
        #2;
        rst = 1'b0;
        q   = 4'b0000;
        #1;
        check_all_zero("s6_async");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("s6_held");
        rst = 1'b1;
        cyc = 0;
        apply_table(9);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
